// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed unified instruction/data memory for the
//               multicycle MIPS controller. Each accepted access waits
//               LATENCY cycles, then commits and reports completion with a
//               one-cycle ready pulse. Misaligned or out-of-range accesses
//               raise err and never modify memory.
// Ports       : clk    - system clock, rising edge
//               reset  - synchronous, active-high reset
//               req    - access request (level, sampled only when idle)
//               we     - 1 = write, 0 = read (sampled with req)
//               addr   - byte address (sampled with req)
//               wdata  - write data (sampled with req)
//               rdata  - read data / write echo, valid while ready=1
//               ready  - one-cycle completion pulse
//               err    - access fault, valid while ready=1
//               busy   - high whenever an access is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
   parameter int DEPTH_LOG2 = 6,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int         c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_LATENCY = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [3:0]            r_cnt;
   logic                  r_we;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rdata;
   logic                  r_err;
   logic [31:0]           r_mem [0:c_DEPTH-1];

   logic [DEPTH_LOG2-1:0] w_index;
   logic                  w_fault;
   logic                  w_commit;
   logic                  w_mem_we;

   // All access decoding works on the captured request, never the live inputs.
   assign w_index  = r_addr[DEPTH_LOG2+1:2];
   assign w_fault  = (r_addr[1:0] != 2'b00) || (r_addr[31:DEPTH_LOG2+2] != '0);
   assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
   // Reset on the commit edge must suppress the write, so it gates the enable.
   assign w_mem_we = w_commit && r_we && !w_fault && !reset;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;  // req deliberately ignored here
         default: w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Request capture, wait counter and response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= c_LATENCY;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else if (w_fault) begin
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end else if (r_we) begin
                  r_rdata <= r_wdata;   // write-through echo
                  r_err   <= 1'b0;
               end else begin
                  r_rdata <= r_mem[w_index];
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage array; contents survive reset
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_index] <= r_wdata;
      end
   end

   assign rdata = r_rdata;
   assign err   = r_err;
   assign ready = (r_state == S_RESP);
   assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire
